// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, widths, the ID/EX register layout and the
// register-match helper used by the hazard and forwarding logic.
package cpu_defs;

   localparam int REG_W  = 3;
   localparam int DATA_W = 16;
   localparam int OP_W   = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'h0,
      OP_SUB = 4'h1,
      OP_AND = 4'h2,
      OP_OR  = 4'h3,
      OP_XOR = 4'h4,
      OP_SLT = 4'h5,
      OP_SLL = 4'h6,
      OP_SRL = 4'h7,
      OP_LW  = 4'h8,
      OP_SW  = 4'h9
   } alu_op_e;

   // Raw source indices and values are kept so forwarding can happen in EX.
   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] rs_val;
      logic [DATA_W-1:0] rt_val;
      logic [DATA_W-1:0] imm;
      logic              use_imm;
      logic              is_load;
      logic              wr_en;
   } ex_reg_t;

   // Register 0 is hard-wired, so a write to it never matches a reader.
   function automatic logic reg_match(input logic             wr_en,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] src);
      return wr_en && (rd == src) && (rd != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection and EX operand selection for id_ex_pipe.
// FORWARD_EN selects bypassing with load-use stalls; otherwise stall on any RAW.
module hazard_fwd_unit
   import cpu_defs::*;
(
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_use_imm,
   input  logic              ex_valid,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic [REG_W-1:0]  ex_rs,
   input  logic [REG_W-1:0]  ex_rt,
   input  logic [DATA_W-1:0] ex_rs_val,
   input  logic [DATA_W-1:0] ex_rt_val,
   input  logic [DATA_W-1:0] ex_imm,
   input  logic              ex_use_imm,
   input  logic              exmem_wr_en,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_wr_en,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              stall,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b
);

   logic hazard;
   logic rt_read;

   assign rt_read = ~id_use_imm;

`ifdef FORWARD_EN
   logic [DATA_W-1:0] rt_fwd;

   // Only a load still in EX cannot be bypassed; everything else forwards.
   always_comb begin
      hazard = id_valid && ex_valid && ex_is_load &&
               (reg_match(ex_wr_en, ex_rd, id_rs) ||
                (rt_read && reg_match(ex_wr_en, ex_rd, id_rt)));
   end

   // MEM is the younger writer, so it beats WB when both target the same register.
   always_comb begin
      ex_a = ex_rs_val;
      if (reg_match(exmem_wr_en, exmem_rd, ex_rs)) begin
         ex_a = exmem_result;
      end else if (reg_match(memwb_wr_en, memwb_rd, ex_rs)) begin
         ex_a = memwb_result;
      end

      rt_fwd = ex_rt_val;
      if (reg_match(exmem_wr_en, exmem_rd, ex_rt)) begin
         rt_fwd = exmem_result;
      end else if (reg_match(memwb_wr_en, memwb_rd, ex_rt)) begin
         rt_fwd = memwb_result;
      end

      ex_b = ex_use_imm ? ex_imm : rt_fwd;
   end
`else
   logic ex_active;
   logic unused_fwd_inputs;

   assign ex_active = ex_valid && ex_wr_en;

   // Without bypassing the reader waits until its producer has retired from WB.
   always_comb begin
      hazard = id_valid &&
               (reg_match(ex_active, ex_rd, id_rs)        ||
                reg_match(exmem_wr_en, exmem_rd, id_rs)   ||
                reg_match(memwb_wr_en, memwb_rd, id_rs)   ||
                (rt_read &&
                 (reg_match(ex_active, ex_rd, id_rt)      ||
                  reg_match(exmem_wr_en, exmem_rd, id_rt) ||
                  reg_match(memwb_wr_en, memwb_rd, id_rt))));
   end

   always_comb begin
      ex_a = ex_rs_val;
      ex_b = ex_use_imm ? ex_imm : ex_rt_val;
   end

   assign unused_fwd_inputs = ^{ex_is_load, ex_rs, ex_rt, exmem_result, memwb_result};
`endif

   assign stall = hazard && !flush && !rst;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with bubble insertion; operand forwarding and stall
// generation come from hazard_fwd_unit. Optional macro: FORWARD_EN.
module id_ex_pipe
   import cpu_defs::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [3:0]        id_op,
   input  logic [2:0]        id_rs,
   input  logic [2:0]        id_rt,
   input  logic [2:0]        id_rd,
   input  logic [15:0]       id_rs_val,
   input  logic [15:0]       id_rt_val,
   input  logic [15:0]       id_imm,
   input  logic              id_use_imm,
   input  logic              id_is_load,
   input  logic              id_wr_en,
   input  logic              flush,
   input  logic              exmem_wr_en,
   input  logic [2:0]        exmem_rd,
   input  logic [15:0]       exmem_result,
   input  logic              memwb_wr_en,
   input  logic [2:0]        memwb_rd,
   input  logic [15:0]       memwb_result,
   output logic              stall,
   output logic              ex_valid,
   output logic [3:0]        ex_op,
   output logic [15:0]       ex_a,
   output logic [15:0]       ex_b,
   output logic [2:0]        ex_rd,
   output logic              ex_wr_en,
   output logic              ex_is_load
);

   ex_reg_t ex_q;
   ex_reg_t ex_d;
   logic    bubble;

   assign bubble = flush || stall || !id_valid;

   // Data fields always follow decode; a bubble only has to clear the control bits.
   always_comb begin
      ex_d.valid   = id_valid;
      ex_d.op      = id_op;
      ex_d.rs      = id_rs;
      ex_d.rt      = id_rt;
      ex_d.rd      = id_rd;
      ex_d.rs_val  = id_rs_val;
      ex_d.rt_val  = id_rt_val;
      ex_d.imm     = id_imm;
      ex_d.use_imm = id_use_imm;
      ex_d.is_load = id_is_load;
      ex_d.wr_en   = id_wr_en;
      if (bubble) begin
         ex_d.valid   = 1'b0;
         ex_d.is_load = 1'b0;
         ex_d.wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   hazard_fwd_unit u_hazard_fwd (
      .rst          (rst),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_imm   (id_use_imm),
      .ex_valid     (ex_q.valid),
      .ex_wr_en     (ex_q.wr_en),
      .ex_is_load   (ex_q.is_load),
      .ex_rd        (ex_q.rd),
      .ex_rs        (ex_q.rs),
      .ex_rt        (ex_q.rt),
      .ex_rs_val    (ex_q.rs_val),
      .ex_rt_val    (ex_q.rt_val),
      .ex_imm       (ex_q.imm),
      .ex_use_imm   (ex_q.use_imm),
      .exmem_wr_en  (exmem_wr_en),
      .exmem_rd     (exmem_rd),
      .exmem_result (exmem_result),
      .memwb_wr_en  (memwb_wr_en),
      .memwb_rd     (memwb_rd),
      .memwb_result (memwb_result),
      .stall        (stall),
      .ex_a         (ex_a),
      .ex_b         (ex_b)
   );

   assign ex_valid   = ex_q.valid;
   assign ex_op      = ex_q.op;
   assign ex_rd      = ex_q.rd;
   assign ex_wr_en   = ex_q.wr_en;
   assign ex_is_load = ex_q.is_load;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed testbench for id_ex_pipe; expectations follow FORWARD_EN when defined,
// otherwise the stall-until-retired behaviour.
module tb_id_ex_pipe;
   import cpu_defs::*;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_op;
   logic [2:0]  id_rs, id_rt, id_rd;
   logic [15:0] id_rs_val, id_rt_val, id_imm;
   logic        id_use_imm, id_is_load, id_wr_en;
   logic        flush;
   logic        exmem_wr_en, memwb_wr_en;
   logic [2:0]  exmem_rd, memwb_rd;
   logic [15:0] exmem_result, memwb_result;
   logic        stall, ex_valid, ex_wr_en, ex_is_load;
   logic [3:0]  ex_op;
   logic [15:0] ex_a, ex_b;
   logic [2:0]  ex_rd;

   int checks = 0;
   int errors = 0;

   id_ex_pipe dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_op(id_op),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_is_load(id_is_load), .id_wr_en(id_wr_en),
      .flush(flush),
      .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
      .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] op,
                                input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                                input logic [15:0] rs_val, input logic [15:0] rt_val,
                                input logic [15:0] imm, input logic use_imm,
                                input logic is_load, input logic wr_en);
      id_valid   = v;
      id_op      = op;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_rs_val  = rs_val;
      id_rt_val  = rt_val;
      id_imm     = imm;
      id_use_imm = use_imm;
      id_is_load = is_load;
      id_wr_en   = wr_en;
      #1;
   endtask

   task automatic setWriters(input logic xw, input logic [2:0] xrd, input logic [15:0] xres,
                             input logic ww, input logic [2:0] wrd, input logic [15:0] wres);
      exmem_wr_en  = xw;
      exmem_rd     = xrd;
      exmem_result = xres;
      memwb_wr_en  = ww;
      memwb_rd     = wrd;
      memwb_result = wres;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      applyStimulus(1, OP_ADD, 3'd1, 3'd0, 3'd2, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
      setWriters(1, 3'd1, 16'h0011, 0, 3'd0, 16'h0000);
      checkOutput("stall_in_rst", {15'b0, stall}, 16'h0000);
      tick();
      checkOutput("rst_valid", {15'b0, ex_valid}, 16'h0000);
      checkOutput("rst_wr_en", {15'b0, ex_wr_en}, 16'h0000);
      checkOutput("rst_is_load", {15'b0, ex_is_load}, 16'h0000);
      checkOutput("rst_a", ex_a, 16'h0000);
      checkOutput("rst_b", ex_b, 16'h0000);
      rst = 1'b0;
      applyStimulus(0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      tick();
      checkOutput("idle_valid", {15'b0, ex_valid}, 16'h0000);

`ifdef FORWARD_EN
      // add r1 then add r2,r1,r1: bypass from MEM, no stall
      applyStimulus(1, OP_ADD, 3'd2, 3'd3, 3'd1, 16'h0002, 16'h0003, 16'h0000, 0, 0, 1);
      tick();
      applyStimulus(1, OP_ADD, 3'd1, 3'd1, 3'd2, 16'h1111, 16'h1111, 16'h0000, 0, 0, 1);
      checkOutput("b2b_stall", {15'b0, stall}, 16'h0000);
      tick();
      setWriters(1, 3'd1, 16'h0005, 0, 3'd0, 16'h0000);
      checkOutput("b2b_valid", {15'b0, ex_valid}, 16'h0001);
      checkOutput("b2b_a", ex_a, 16'h0005);
      checkOutput("b2b_b", ex_b, 16'h0005);

      // double match on r3: MEM beats WB, then WB alone
      applyStimulus(1, OP_ADD, 3'd3, 3'd3, 3'd4, 16'h0333, 16'h0333, 16'h0000, 0, 0, 1);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      tick();
      setWriters(1, 3'd3, 16'h00AA, 1, 3'd3, 16'h0055);
      checkOutput("dbl_a", ex_a, 16'h00AA);
      setWriters(0, 3'd0, 16'h0000, 1, 3'd3, 16'h0055);
      checkOutput("wb_fwd_a", ex_a, 16'h0055);

      // immediate operand is never forwarded over
      applyStimulus(1, OP_ADD, 3'd1, 3'd2, 3'd5, 16'h0101, 16'h0202, 16'h00F0, 1, 0, 1);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      tick();
      setWriters(1, 3'd2, 16'h9999, 0, 3'd0, 16'h0000);
      checkOutput("imm_b", ex_b, 16'h00F0);
      checkOutput("imm_a", ex_a, 16'h0101);

      // r0 is never a match
      applyStimulus(1, OP_LW, 3'd1, 3'd0, 3'd0, 16'h0010, 16'h0000, 16'h0004, 1, 1, 1);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      tick();
      applyStimulus(1, OP_ADD, 3'd0, 3'd0, 3'd6, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
      checkOutput("r0_stall", {15'b0, stall}, 16'h0000);
      tick();
      setWriters(1, 3'd0, 16'hFFFF, 1, 3'd0, 16'hFFFF);
      checkOutput("r0_a", ex_a, 16'h0000);

      // load r4 then use: one stall, one bubble, WB-forwarded operand
      applyStimulus(1, OP_LW, 3'd1, 3'd0, 3'd4, 16'h0010, 16'h0000, 16'h0004, 1, 1, 1);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      tick();
      applyStimulus(1, OP_ADD, 3'd4, 3'd5, 3'd6, 16'h0BAD, 16'h0007, 16'h0000, 0, 0, 1);
      checkOutput("lu_stall", {15'b0, stall}, 16'h0001);
      tick();
      setWriters(1, 3'd4, 16'h1234, 0, 3'd0, 16'h0000);
      checkOutput("lu_bubble_valid", {15'b0, ex_valid}, 16'h0000);
      checkOutput("lu_bubble_wr_en", {15'b0, ex_wr_en}, 16'h0000);
      checkOutput("lu_stall_once", {15'b0, stall}, 16'h0000);
      tick();
      setWriters(0, 3'd0, 16'h0000, 1, 3'd4, 16'h1234);
      checkOutput("lu_issue_valid", {15'b0, ex_valid}, 16'h0001);
      checkOutput("lu_issue_a", ex_a, 16'h1234);
      checkOutput("lu_issue_b", ex_b, 16'h0007);

      // load r2; an immediate-form reader of rt=r2 does not stall
      applyStimulus(1, OP_LW, 3'd1, 3'd0, 3'd2, 16'h0010, 16'h0000, 16'h0004, 1, 1, 1);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      tick();
      applyStimulus(1, OP_ADD, 3'd3, 3'd2, 3'd5, 16'h0303, 16'h0202, 16'h0040, 1, 0, 1);
      checkOutput("imm_no_stall", {15'b0, stall}, 16'h0000);

      // hazard plus flush: flush wins
      applyStimulus(1, OP_ADD, 3'd2, 3'd3, 3'd5, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
      checkOutput("fl_hazard", {15'b0, stall}, 16'h0001);
      flush = 1'b1;
      #1;
      checkOutput("fl_stall", {15'b0, stall}, 16'h0000);
      tick();
      flush = 1'b0;
      checkOutput("fl_valid", {15'b0, ex_valid}, 16'h0000);

      // reset during a load-use stall
      applyStimulus(1, OP_LW, 3'd1, 3'd0, 3'd4, 16'h0010, 16'h0000, 16'h0004, 1, 1, 1);
      tick();
      applyStimulus(1, OP_SUB, 3'd4, 3'd4, 3'd6, 16'h0AAA, 16'h0AAA, 16'h0000, 0, 0, 1);
      checkOutput("mr_stall", {15'b0, stall}, 16'h0001);
`else
      // RAW on r1 stalls while the writer is in EX, MEM and WB
      applyStimulus(1, OP_ADD, 3'd2, 3'd3, 3'd1, 16'h0002, 16'h0003, 16'h0000, 0, 0, 1);
      tick();
      applyStimulus(1, OP_ADD, 3'd1, 3'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 0, 0, 1);
      checkOutput("raw_ex_stall", {15'b0, stall}, 16'h0001);
      tick();
      setWriters(1, 3'd1, 16'h0005, 0, 3'd0, 16'h0000);
      checkOutput("raw_bubble", {15'b0, ex_valid}, 16'h0000);
      checkOutput("raw_mem_stall", {15'b0, stall}, 16'h0001);
      tick();
      setWriters(0, 3'd0, 16'h0000, 1, 3'd1, 16'h0005);
      checkOutput("raw_wb_stall", {15'b0, stall}, 16'h0001);
      tick();
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      checkOutput("raw_done", {15'b0, stall}, 16'h0000);
      tick();
      checkOutput("raw_issue_valid", {15'b0, ex_valid}, 16'h0001);
      checkOutput("raw_issue_a", ex_a, 16'h0005);
      checkOutput("raw_issue_b", ex_b, 16'h0005);
      setWriters(1, 3'd1, 16'hEEEE, 0, 3'd0, 16'h0000);
      checkOutput("no_fwd_a", ex_a, 16'h0005);

      // hazard against EX writer r2 plus flush: flush wins
      applyStimulus(1, OP_ADD, 3'd2, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
      checkOutput("fl_hazard", {15'b0, stall}, 16'h0001);
      flush = 1'b1;
      #1;
      checkOutput("fl_stall", {15'b0, stall}, 16'h0000);
      tick();
      flush = 1'b0;
      checkOutput("fl_valid", {15'b0, ex_valid}, 16'h0000);

      // r0 writers never stall
      setWriters(1, 3'd0, 16'hFFFF, 1, 3'd0, 16'hFFFF);
      applyStimulus(1, OP_ADD, 3'd0, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
      checkOutput("r0_stall", {15'b0, stall}, 16'h0000);

      // immediate form ignores rt match; ex_b takes the immediate
      applyStimulus(1, OP_ADD, 3'd3, 3'd2, 3'd5, 16'h0303, 16'h0202, 16'h0040, 1, 0, 1);
      setWriters(1, 3'd2, 16'h9999, 0, 3'd0, 16'h0000);
      checkOutput("imm_no_stall", {15'b0, stall}, 16'h0000);
      tick();
      checkOutput("imm_b", ex_b, 16'h0040);

      // invalid decode slot never stalls
      applyStimulus(0, OP_ADD, 3'd2, 3'd2, 3'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
      checkOutput("inv_stall", {15'b0, stall}, 16'h0000);

      // reset during a RAW stall
      applyStimulus(1, OP_SUB, 3'd2, 3'd2, 3'd6, 16'h0AAA, 16'h0AAA, 16'h0000, 0, 0, 1);
      checkOutput("mr_stall", {15'b0, stall}, 16'h0001);
`endif
      rst = 1'b1;
      #1;
      checkOutput("mr_rst_stall", {15'b0, stall}, 16'h0000);
      tick();
      rst = 1'b0;
      applyStimulus(0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      setWriters(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      checkOutput("mr_valid", {15'b0, ex_valid}, 16'h0000);
      checkOutput("mr_wr_en", {15'b0, ex_wr_en}, 16'h0000);
      checkOutput("mr_is_load", {15'b0, ex_is_load}, 16'h0000);
      checkOutput("mr_op", {12'b0, ex_op}, 16'h0000);
      checkOutput("mr_rd", {13'b0, ex_rd}, 16'h0000);
      checkOutput("mr_a", ex_a, 16'h0000);
      checkOutput("mr_b", ex_b, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
